// File: rtl/pipe_hazard_fsm_if.sv
// pipe_hazard_fsm_if: hazard-unit bundle; master = pipeline/decoder side, slave = hazard sequencer
interface pipe_hazard_fsm_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] id_rs, id_rt, exe_wa, mem_wa;
    logic id_rs_used, id_rt_used, id_is_store;
    logic exe_wen, mem_wen, exe_is_load, mem_is_load;
    logic mem_req, dmem_ack, trap_req;
    logic [1:0] fwd_a, fwd_b;
    logic fwd_m;
    logic if_en, id_en, exe_en, mem_en, wb_en;
    logic if_rst, id_rst, exe_rst, mem_rst, wb_rst;
    logic trap_redirect, trap_ack, mem_timeout;
    modport master (
        output id_rs, id_rt, id_rs_used, id_rt_used, id_is_store, exe_wa, mem_wa,
               exe_wen, mem_wen, exe_is_load, mem_is_load, mem_req, dmem_ack, trap_req,
        input  fwd_a, fwd_b, fwd_m, if_en, id_en, exe_en, mem_en, wb_en,
               if_rst, id_rst, exe_rst, mem_rst, wb_rst, trap_redirect, trap_ack, mem_timeout
    );
    modport slave (
        input  id_rs, id_rt, id_rs_used, id_rt_used, id_is_store, exe_wa, mem_wa,
               exe_wen, mem_wen, exe_is_load, mem_is_load, mem_req, dmem_ack, trap_req,
        output fwd_a, fwd_b, fwd_m, if_en, id_en, exe_en, mem_en, wb_en,
               if_rst, id_rst, exe_rst, mem_rst, wb_rst, trap_redirect, trap_ack, mem_timeout
    );
endinterface

// File: rtl/pipe_hazard_fsm.sv
// pipe_hazard_fsm: forwarding, load-use, dmem-wait and trap sequencer; HAZARD_PERF_EN adds perf counters
module pipe_hazard_fsm #(
    parameter int REG_AW = 5,
    parameter int TIMEOUT_W = 4,
    parameter int TIMEOUT_MAX = 15
`ifdef HAZARD_PERF_EN
    , parameter int PERF_W = 32
`endif
) (
    input  logic clk,
    input  logic rst,
    pipe_hazard_fsm_if.slave hz
`ifdef HAZARD_PERF_EN
    , output logic [PERF_W-1:0] perf_lu_stall_o,
    output logic [PERF_W-1:0] perf_mem_stall_o,
    output logic [PERF_W-1:0] perf_traps_o
`endif
);
    typedef enum logic [1:0] {RUN, MWAIT, TRAP} state_e;
    state_e state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic trap_pend_q, trap_pend_d;
    logic exe_ok, mem_ok, exe_rs, exe_rt, mem_rs, mem_rt, load_use;
    assign exe_ok = hz.exe_wen && hz.exe_wa != REG_AW'(0);
    assign mem_ok = hz.mem_wen && hz.mem_wa != REG_AW'(0);
    assign exe_rs = exe_ok && hz.exe_wa == hz.id_rs;
    assign exe_rt = exe_ok && hz.exe_wa == hz.id_rt;
    assign mem_rs = mem_ok && hz.mem_wa == hz.id_rs;
    assign mem_rt = mem_ok && hz.mem_wa == hz.id_rt;
    assign load_use = hz.exe_is_load && ((hz.id_rs_used && exe_rs) || (hz.id_rt_used && exe_rt && !hz.id_is_store));
    always_comb begin
        hz.fwd_a = rst ? 2'd0 : exe_rs ? 2'd1 : mem_rs ? (hz.mem_is_load ? 2'd3 : 2'd2) : 2'd0;
        hz.fwd_b = rst ? 2'd0 : exe_rt ? 2'd1 : mem_rt ? (hz.mem_is_load ? 2'd3 : 2'd2) : 2'd0;
        hz.fwd_m = !rst && hz.exe_is_load && exe_rt && hz.id_is_store && hz.id_rt_used;
    end
    always_ff @(posedge clk) begin
        state_q <= rst ? RUN : state_d;
        cnt_q <= rst ? '0 : cnt_d;
        trap_pend_q <= rst ? 1'b0 : trap_pend_d;
    end
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        trap_pend_d = trap_pend_q;
        {hz.if_en, hz.id_en, hz.exe_en, hz.mem_en, hz.wb_en} = '1;
        {hz.if_rst, hz.id_rst, hz.exe_rst, hz.mem_rst, hz.wb_rst} = '0;
        hz.trap_redirect = 1'b0;
        hz.trap_ack = 1'b0;
        hz.mem_timeout = 1'b0;
        if (rst) begin
            {hz.if_rst, hz.id_rst, hz.exe_rst, hz.mem_rst, hz.wb_rst} = '1;
        end else begin
            case (state_q)
                RUN: begin
                    if (trap_pend_q || hz.trap_req) begin
                        {hz.id_rst, hz.exe_rst, hz.mem_rst} = '1;
                        hz.trap_redirect = 1'b1;
                        hz.trap_ack = 1'b1;
                        trap_pend_d = 1'b0;
                        state_d = TRAP;
                    end else if (hz.mem_req && !hz.dmem_ack) begin
                        {hz.if_en, hz.id_en, hz.exe_en, hz.mem_en} = '0;
                        hz.wb_rst = 1'b1;
                        cnt_d = TIMEOUT_W'(1);
                        state_d = MWAIT;
                    end else if (load_use) begin
                        {hz.if_en, hz.id_en} = '0;
                        hz.exe_rst = 1'b1;
                    end
                end
                MWAIT: begin
                    // a trap arriving mid-wait is held until the pipeline is released
                    trap_pend_d = trap_pend_q || hz.trap_req;
                    if (hz.dmem_ack) begin
                        cnt_d = '0;
                        state_d = RUN;
                    end else begin
                        {hz.if_en, hz.id_en, hz.exe_en, hz.mem_en} = '0;
                        hz.wb_rst = 1'b1;
                        if (cnt_q == TIMEOUT_W'(TIMEOUT_MAX)) begin
                            hz.mem_timeout = 1'b1;
                            trap_pend_d = 1'b1;
                            cnt_d = '0;
                            state_d = RUN;
                        end else begin
                            cnt_d = cnt_q + TIMEOUT_W'(1);
                        end
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end
`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_stall_o <= '0;
            perf_mem_stall_o <= '0;
            perf_traps_o <= '0;
        end else begin
            if (!hz.id_en && hz.exe_en && !(&perf_lu_stall_o)) perf_lu_stall_o <= perf_lu_stall_o + PERF_W'(1);
            if (state_q == MWAIT && !(&perf_mem_stall_o)) perf_mem_stall_o <= perf_mem_stall_o + PERF_W'(1);
            if (hz.trap_ack && !(&perf_traps_o)) perf_traps_o <= perf_traps_o + PERF_W'(1);
        end
    end
`endif
endmodule
